// File: rtl/pwd_pkg.sv
// pwd_pkg: shared lock types and digit geometry
package pwd_pkg;
  localparam int PWD_DIGITS = 3;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_NIBBLE = 4'hF;
  typedef enum logic [2:0] {IDLE, D0, D1, D2, WAIT_CONF, PASS, FAIL, LOCK} state_t;
endpackage

// File: rtl/pwd_check_if.sv
// pwd_check_if: keypad/password inputs and verification results
interface pwd_check_if;
  import pwd_pkg::*;
  logic check;
  logic confirm;
  logic keyboard_en;
  logic [DIGIT_W-1:0] keyboard_num;
  logic setend;
  logic [PWD_DIGITS*DIGIT_W-1:0] setnum;
  logic [PWD_DIGITS*DIGIT_W-1:0] entered;
  logic [PWD_DIGITS-1:0] seat;
  logic pass_led;
  logic fail_led;
  logic alarm;
  logic [1:0] tries_left;
  modport master (
    output check, confirm, keyboard_en, keyboard_num, setend, setnum,
    input entered, seat, pass_led, fail_led, alarm, tries_left
  );
  modport slave (
    input check, confirm, keyboard_en, keyboard_num, setend, setnum,
    output entered, seat, pass_led, fail_led, alarm, tries_left
  );
endinterface

// File: rtl/lock_timer.sv
// lock_timer: one-shot countdown; done while the count sits at zero
module lock_timer #(
  parameter int LOCK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);
  localparam int W = $clog2(LOCK_CYCLES);
  logic [W-1:0] cnt;
  // load on start, then count down to zero and hold
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (start) cnt <= W'(LOCK_CYCLES - 1);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/pwd_check.sv
// pwd_check: collects a 3-digit attempt, compares with stored password, locks out after repeated failures
module pwd_check
  import pwd_pkg::*;
#(
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYCLES = 100_000_000
) (
  input logic clk,
  input logic rst,
  pwd_check_if.slave bus
);
  state_t st, nxt;
  logic [1:0] fail_cnt, fail_nxt, fail_inc, idx;
  logic [PWD_DIGITS*DIGIT_W-1:0] entered;
  logic [PWD_DIGITS-1:0] seat;
  logic clr, wr, done;
  assign fail_inc = fail_cnt + 2'd1;
  assign idx = st == D0 ? 2'd2 : st == D1 ? 2'd1 : 2'd0;
  assign bus.entered = entered;
  assign bus.seat = seat;
  assign bus.tries_left = 2'(MAX_TRIES) - fail_cnt;
  lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .start(nxt == LOCK && st != LOCK),
    .done(done)
  );
  // next state with priority setend abort > check restart > confirm > digit strobe
  always_comb begin
    nxt = st;
    fail_nxt = fail_cnt;
    clr = 1'b0;
    wr = 1'b0;
    case (st)
      IDLE: if (bus.check && bus.setend) begin nxt = D0; clr = 1'b1; end
      LOCK: if (done) begin nxt = IDLE; fail_nxt = '0; end
      default:
        if (!bus.setend) begin nxt = IDLE; clr = 1'b1; end
        else if (bus.check) begin nxt = D0; clr = 1'b1; end
        else if (st == WAIT_CONF && bus.confirm) begin
          fail_nxt = entered == bus.setnum ? 2'd0 : fail_inc;
          nxt = entered == bus.setnum ? PASS : fail_inc == 2'(MAX_TRIES) ? LOCK : FAIL;
        end
        else if (bus.keyboard_en && (st == D0 || st == D1 || st == D2)) begin
          wr = 1'b1;
          nxt = st == D0 ? D1 : st == D1 ? D2 : WAIT_CONF;
        end
    endcase
  end
  // state, failure count and registered Moore indications
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      fail_cnt <= '0;
      bus.pass_led <= 1'b0;
      bus.fail_led <= 1'b0;
      bus.alarm <= 1'b0;
    end else begin
      st <= nxt;
      fail_cnt <= fail_nxt;
      bus.pass_led <= nxt == PASS;
      bus.fail_led <= nxt == FAIL;
      bus.alarm <= nxt == LOCK;
    end
  // entry buffer: blanked on restart/abort, one nibble per accepted digit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      entered <= {PWD_DIGITS{BLANK_NIBBLE}};
      seat <= '1;
    end else if (clr) begin
      entered <= {PWD_DIGITS{BLANK_NIBBLE}};
      seat <= '1;
    end else if (wr) begin
      entered[idx*DIGIT_W +: DIGIT_W] <= bus.keyboard_num;
      seat[idx] <= 1'b0;
    end
endmodule

// File: tb/tb_pwd_check.sv
// tb_pwd_check: directed checks of entry, compare, restart/abort and lockout
module tb_pwd_check;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int alarm_cycles;
  pwd_check_if bus();
  pwd_check #(.MAX_TRIES(3), .LOCK_CYCLES(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [3:0] d);
    bus.keyboard_en = 1'b1;
    bus.keyboard_num = d;
    cyc();
    bus.keyboard_en = 1'b0;
  endtask
  task automatic start_entry;
    bus.check = 1'b1;
    cyc();
    bus.check = 1'b0;
  endtask
  task automatic submit;
    bus.confirm = 1'b1;
    cyc();
    bus.confirm = 1'b0;
  endtask
  task automatic attempt(input logic [11:0] v);
    start_entry();
    press(v[11:8]);
    press(v[7:4]);
    press(v[3:0]);
    submit();
  endtask
  initial begin
    bus.check = 1'b0;
    bus.confirm = 1'b0;
    bus.keyboard_en = 1'b0;
    bus.keyboard_num = 4'h0;
    bus.setend = 1'b0;
    bus.setnum = 12'h123;
    cyc(2);
    chk("rst_entered", bus.entered, 12'hFFF);
    chk("rst_seat", bus.seat, 3'b111);
    chk("rst_pass", bus.pass_led, 1'b0);
    chk("rst_fail", bus.fail_led, 1'b0);
    chk("rst_alarm", bus.alarm, 1'b0);
    chk("rst_tries", bus.tries_left, 2'd3);
    rst = 1'b0;
    cyc();
    start_entry();
    press(4'h1);
    chk("check_no_setend", bus.entered, 12'hFFF);
    bus.setend = 1'b1;
    cyc();
    start_entry();
    chk("d0_entered", bus.entered, 12'hFFF);
    press(4'h1);
    chk("dig0_entered", bus.entered, 12'h1FF);
    chk("dig0_seat", bus.seat, 3'b011);
    press(4'h2);
    chk("dig1_entered", bus.entered, 12'h12F);
    chk("dig1_seat", bus.seat, 3'b001);
    press(4'h3);
    chk("dig2_entered", bus.entered, 12'h123);
    chk("dig2_seat", bus.seat, 3'b000);
    submit();
    chk("ok_pass", bus.pass_led, 1'b1);
    chk("ok_fail", bus.fail_led, 1'b0);
    chk("ok_tries", bus.tries_left, 2'd3);
    attempt(12'h124);
    chk("bad_fail", bus.fail_led, 1'b1);
    chk("bad_pass", bus.pass_led, 1'b0);
    chk("bad_tries", bus.tries_left, 2'd2);
    attempt(12'h123);
    chk("retry_pass", bus.pass_led, 1'b1);
    chk("retry_tries", bus.tries_left, 2'd3);
    start_entry();
    press(4'h1);
    press(4'h2);
    chk("partial", bus.entered, 12'h12F);
    start_entry();
    chk("restart_entered", bus.entered, 12'hFFF);
    chk("restart_seat", bus.seat, 3'b111);
    press(4'h7);
    chk("restart_d0", bus.entered, 12'h7FF);
    bus.setend = 1'b0;
    cyc();
    chk("abort_entered", bus.entered, 12'hFFF);
    chk("abort_seat", bus.seat, 3'b111);
    bus.setend = 1'b1;
    press(4'h5);
    chk("abort_idle", bus.entered, 12'hFFF);
    start_entry();
    press(4'h1);
    press(4'h2);
    press(4'h3);
    bus.confirm = 1'b1;
    bus.keyboard_en = 1'b1;
    bus.keyboard_num = 4'h9;
    cyc();
    bus.confirm = 1'b0;
    bus.keyboard_en = 1'b0;
    chk("simul_pass", bus.pass_led, 1'b1);
    chk("simul_entered", bus.entered, 12'h123);
    start_entry();
    submit();
    chk("conf_d0_pass", bus.pass_led, 1'b0);
    chk("conf_d0_fail", bus.fail_led, 1'b0);
    press(4'h1);
    chk("conf_d0_stay", bus.entered, 12'h1FF);
    attempt(12'h999);
    chk("lk1_tries", bus.tries_left, 2'd2);
    attempt(12'h999);
    chk("lk2_fail", bus.fail_led, 1'b1);
    chk("lk2_tries", bus.tries_left, 2'd1);
    attempt(12'h999);
    chk("lk3_alarm", bus.alarm, 1'b1);
    chk("lk3_fail", bus.fail_led, 1'b0);
    chk("lk3_tries", bus.tries_left, 2'd0);
    alarm_cycles = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.alarm) alarm_cycles++;
      bus.check = i < 8;
      bus.keyboard_en = i < 8;
      bus.keyboard_num = 4'h1;
      cyc();
    end
    bus.check = 1'b0;
    bus.keyboard_en = 1'b0;
    chk("lock_len", alarm_cycles, 10);
    chk("unlock_alarm", bus.alarm, 1'b0);
    chk("unlock_tries", bus.tries_left, 2'd3);
    chk("lock_ignored", bus.entered, 12'h999);
    attempt(12'h456);
    attempt(12'h456);
    attempt(12'h456);
    chk("lk_again", bus.alarm, 1'b1);
    cyc(3);
    rst = 1'b1;
    #2;
    chk("arst_alarm", bus.alarm, 1'b0);
    chk("arst_tries", bus.tries_left, 2'd3);
    chk("arst_entered", bus.entered, 12'hFFF);
    chk("arst_seat", bus.seat, 3'b111);
    cyc();
    rst = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
